// File: rtl/exe_stage_module_if.sv
// Execute-stage bus: ID/EX inputs into the stage, EX/MEM and feedback outputs out of it.
// master = upstream/downstream pipeline side, slave = the execute stage itself.
interface exe_stage_module_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned REG_W = 4
) ();

    // MEM stall
    logic             freeze;

    // ID/EX pipeline register contents
    logic             wb_enable_in;
    logic             mem_read_in;
    logic             mem_write_in;
    logic             branch_en_in;
    logic             S_in;
    logic [3:0]       exec_cmd;
    logic [WIDTH-1:0] PC_in;
    logic [WIDTH-1:0] Val_Rn;
    logic [WIDTH-1:0] Val_Rm;
    logic             immediate;
    logic [11:0]      Shift_operand;
    logic [23:0]      Signed_imm_24;
    logic [REG_W-1:0] Dest_in;
    logic [3:0]       Status_in;

    // Branch resolution back to IF/ID
    logic             branch_taken;
    logic [WIDTH-1:0] branch_address;

    // Status register feedback to ID
    logic [3:0]       status_out;

    // EX/MEM pipeline register contents
    logic             wb_enable;
    logic             mem_read;
    logic             mem_write;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] store_val;
    logic [REG_W-1:0] Dest;

    modport master (
        output freeze,
        output wb_enable_in, mem_read_in, mem_write_in, branch_en_in, S_in,
        output exec_cmd, PC_in, Val_Rn, Val_Rm, immediate, Shift_operand,
        output Signed_imm_24, Dest_in, Status_in,
        input  branch_taken, branch_address, status_out,
        input  wb_enable, mem_read, mem_write, alu_result, store_val, Dest
    );

    modport slave (
        input  freeze,
        input  wb_enable_in, mem_read_in, mem_write_in, branch_en_in, S_in,
        input  exec_cmd, PC_in, Val_Rn, Val_Rm, immediate, Shift_operand,
        input  Signed_imm_24, Dest_in, Status_in,
        output branch_taken, branch_address, status_out,
        output wb_enable, mem_read, mem_write, alu_result, store_val, Dest
    );

endinterface

// File: rtl/exe_stage_module.sv
// Execute stage: builds the second operand (Val2), runs the ALU, resolves the branch target,
// owns the {N,Z,C,V} status register and registers results into EX/MEM.
module exe_stage_module #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned REG_W = 4
) (
    input logic               clk,
    input logic               rst,
    exe_stage_module_if.slave bus
);

    localparam int unsigned MSB = WIDTH - 1;

    // ALU opcodes
    localparam logic [3:0] CmdMov = 4'b0001;
    localparam logic [3:0] CmdMvn = 4'b1001;
    localparam logic [3:0] CmdAdd = 4'b0010;
    localparam logic [3:0] CmdAdc = 4'b0011;
    localparam logic [3:0] CmdSub = 4'b0100;
    localparam logic [3:0] CmdSbc = 4'b0101;
    localparam logic [3:0] CmdAnd = 4'b0110;
    localparam logic [3:0] CmdOrr = 4'b0111;
    localparam logic [3:0] CmdEor = 4'b1000;

    // Shift types in Shift_operand[6:5]
    localparam logic [1:0] ShLsl = 2'b00;
    localparam logic [1:0] ShLsr = 2'b01;
    localparam logic [1:0] ShAsr = 2'b10;
    localparam logic [1:0] ShRor = 2'b11;

    // Operand generation
    logic [WIDTH-1:0]   val2;
    logic [WIDTH-1:0]   imm32;
    logic [4:0]         rot_amt;
    logic [4:0]         sh_amt;
    logic [2*WIDTH-1:0] rot_dbl;

    // ALU
    logic [WIDTH-1:0]   alu_res;
    logic [WIDTH-1:0]   add_b;
    logic               add_cin;
    logic [WIDTH:0]     add_sum;
    logic               is_arith;
    logic               op_valid;
    logic               c_flag;
    logic               v_flag;
    logic [3:0]         alu_flags;

    // Status register
    logic [3:0]         status_d, status_q;

    // EX/MEM register
    logic               wb_enable_d, wb_enable_q;
    logic               mem_read_d, mem_read_q;
    logic               mem_write_d, mem_write_q;
    logic [WIDTH-1:0]   alu_result_d, alu_result_q;
    logic [WIDTH-1:0]   store_val_d, store_val_q;
    logic [REG_W-1:0]   dest_d, dest_q;

    // Val2 select: memory offset, rotated immediate, or shifted register.
    always_comb begin
        val2    = '0;
        rot_dbl = '0;
        imm32   = {{(WIDTH - 8){1'b0}}, bus.Shift_operand[7:0]};
        rot_amt = {bus.Shift_operand[11:8], 1'b0};
        sh_amt  = bus.Shift_operand[11:7];
        if (bus.mem_read_in || bus.mem_write_in) begin
            val2 = {{(WIDTH - 12){1'b0}}, bus.Shift_operand};
        end else if (bus.immediate) begin
            // Rotate right by taking the low half of the doubled word shifted right.
            rot_dbl = {imm32, imm32} >> rot_amt;
            val2    = rot_dbl[WIDTH-1:0];
        end else if (sh_amt == 5'd0) begin
            // Amount zero passes Rm through for every shift type.
            val2 = bus.Val_Rm;
        end else begin
            unique case (bus.Shift_operand[6:5])
                ShLsl: val2 = bus.Val_Rm << sh_amt;
                ShLsr: val2 = bus.Val_Rm >> sh_amt;
                ShAsr: val2 = $signed(bus.Val_Rm) >>> sh_amt;
                ShRor: begin
                    rot_dbl = {bus.Val_Rm, bus.Val_Rm} >> sh_amt;
                    val2    = rot_dbl[WIDTH-1:0];
                end
                default: val2 = bus.Val_Rm;
            endcase
        end
    end

    // ALU: one shared adder serves ADD/ADC/SUB/SBC (subtract = add inverted operand + carry).
    always_comb begin
        alu_res  = '0;
        add_b    = val2;
        add_cin  = 1'b0;
        is_arith = 1'b0;
        op_valid = 1'b1;
        c_flag   = bus.Status_in[1];
        v_flag   = bus.Status_in[0];
        case (bus.exec_cmd)
            CmdMov: alu_res = val2;
            CmdMvn: alu_res = ~val2;
            CmdAdd: is_arith = 1'b1;
            CmdAdc: begin
                is_arith = 1'b1;
                add_cin  = bus.Status_in[1];
            end
            CmdSub: begin
                is_arith = 1'b1;
                add_b    = ~val2;
                add_cin  = 1'b1;
            end
            CmdSbc: begin
                // Rn - Val2 - !C == Rn + ~Val2 + C
                is_arith = 1'b1;
                add_b    = ~val2;
                add_cin  = bus.Status_in[1];
            end
            CmdAnd: alu_res = bus.Val_Rn & val2;
            CmdOrr: alu_res = bus.Val_Rn | val2;
            CmdEor: alu_res = bus.Val_Rn ^ val2;
            default: begin
                alu_res  = '0;
                op_valid = 1'b0;
            end
        endcase
        add_sum = {1'b0, bus.Val_Rn} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
        if (is_arith) begin
            alu_res = add_sum[WIDTH-1:0];
            // Carry-out of the inverted-operand add is already NOT borrow for subtracts.
            c_flag  = add_sum[WIDTH];
            v_flag  = (bus.Val_Rn[MSB] == add_b[MSB]) && (alu_res[MSB] != bus.Val_Rn[MSB]);
        end
        alu_flags = {alu_res[MSB], (alu_res == '0), c_flag, v_flag};
    end

    // Next-state for the status register and the EX/MEM register.
    always_comb begin
        status_d     = status_q;
        wb_enable_d  = wb_enable_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        alu_result_d = alu_result_q;
        store_val_d  = store_val_q;
        dest_d       = dest_q;
        // Unknown opcodes leave flags alone even with S set.
        if (bus.S_in && !bus.freeze && !bus.branch_en_in && op_valid) begin
            status_d = alu_flags;
        end
        if (!bus.freeze) begin
            wb_enable_d  = bus.wb_enable_in;
            mem_read_d   = bus.mem_read_in;
            mem_write_d  = bus.mem_write_in;
            alu_result_d = alu_res;
            store_val_d  = bus.Val_Rm;
            dest_d       = bus.Dest_in;
        end
    end

    // State registers; reset clears everything asynchronously, even during a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q     <= 4'b0000;
            wb_enable_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            alu_result_q <= '0;
            store_val_q  <= '0;
            dest_q       <= '0;
        end else begin
            status_q     <= status_d;
            wb_enable_q  <= wb_enable_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            alu_result_q <= alu_result_d;
            store_val_q  <= store_val_d;
            dest_q       <= dest_d;
        end
    end

    // Branch resolution is combinational so IF/ID can flush in the same cycle.
    assign bus.branch_taken   = bus.branch_en_in;
    assign bus.branch_address = bus.PC_in + {{6{bus.Signed_imm_24[23]}}, bus.Signed_imm_24, 2'b00};

    assign bus.status_out = status_q;
    assign bus.wb_enable  = wb_enable_q;
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.alu_result = alu_result_q;
    assign bus.store_val  = store_val_q;
    assign bus.Dest       = dest_q;

endmodule

// File: tb/tb_exe_stage_module.sv
// Bench for exe_stage_module: directed cases followed by randomized instructions checked
// against an arithmetic reference model.
module tb_exe_stage_module;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    exe_stage_module_if bus ();

    exe_stage_module dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference state
    logic [31:0] m_alu, m_store;
    logic        m_wb, m_mr, m_mw;
    logic [3:0]  m_dest, m_status;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_alu = 0; m_store = 0; m_wb = 0; m_mr = 0; m_mw = 0; m_dest = 0; m_status = 0;
    endtask

    task automatic clear_in();
        bus.freeze = 0; bus.wb_enable_in = 0; bus.mem_read_in = 0; bus.mem_write_in = 0;
        bus.branch_en_in = 0; bus.S_in = 0; bus.exec_cmd = 0; bus.PC_in = 0;
        bus.Val_Rn = 0; bus.Val_Rm = 0; bus.immediate = 0; bus.Shift_operand = 0;
        bus.Signed_imm_24 = 0; bus.Dest_in = 0; bus.Status_in = 0;
    endtask

    function automatic logic [31:0] ror1(input logic [31:0] x, input int n);
        logic [31:0] y = x;
        repeat (n) y = y / 2 + (y % 2) * 32'h8000_0000;
        return y;
    endfunction

    // Expected ALU result and flags from the current inputs.
    task automatic predict(output logic [31:0] res, output logic [3:0] flags, output bit valid);
        logic [31:0] v2, rn, rm;
        logic [3:0]  st;
        longint      u, s, p, q, sr;
        int          n;
        bit          cin, c, v, arith, is_add;
        rn = bus.Val_Rn; rm = bus.Val_Rm; st = bus.Status_in; cin = st[1];
        if (bus.mem_read_in || bus.mem_write_in) begin
            v2 = 32'(bus.Shift_operand);
        end else if (bus.immediate) begin
            v2 = ror1(32'(bus.Shift_operand[7:0]), 2 * int'(bus.Shift_operand[11:8]));
        end else begin
            n = int'(bus.Shift_operand[11:7]);
            p = 1;
            repeat (n) p = p * 2;
            case (bus.Shift_operand[6:5])
                2'd0: v2 = 32'(longint'({32'b0, rm}) * p);
                2'd1: v2 = 32'(longint'({32'b0, rm}) / p);
                2'd2: begin
                    sr = longint'($signed(rm));
                    q = sr / p;
                    if (sr < 0 && (sr % p) != 0) q = q - 1;
                    v2 = 32'(q);
                end
                default: v2 = ror1(rm, n);
            endcase
        end
        valid = 1; arith = 0; is_add = 0; res = 0; c = st[1]; v = st[0]; u = 0; s = 0;
        case (bus.exec_cmd)
            4'd1: res = v2;
            4'd9: res = ~v2;
            4'd2, 4'd3: begin
                arith = 1; is_add = 1;
                u = longint'({32'b0, rn}) + longint'({32'b0, v2});
                s = longint'($signed(rn)) + longint'($signed(v2));
                if (bus.exec_cmd == 4'd3) begin u = u + cin; s = s + cin; end
            end
            4'd4, 4'd5: begin
                arith = 1;
                u = longint'({32'b0, rn}) - longint'({32'b0, v2});
                s = longint'($signed(rn)) - longint'($signed(v2));
                if (bus.exec_cmd == 4'd5) begin u = u - (1 - cin); s = s - (1 - cin); end
            end
            4'd6: res = rn & v2;
            4'd7: res = rn | v2;
            4'd8: res = rn ^ v2;
            default: valid = 0;
        endcase
        if (arith) begin
            res = u[31:0];
            c = is_add ? (u >= 64'sd4294967296) : (u >= 0);
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
        flags = {res[31], res == 0, c, v};
    endtask

    // One clock: check combinational branch outputs, clock, then check registered outputs.
    task automatic step(input string tag);
        logic [31:0] r, exp_ba;
        logic [3:0]  f;
        bit          v;
        #1;
        exp_ba = 32'(longint'({32'b0, bus.PC_in}) + 4 * longint'($signed(bus.Signed_imm_24)));
        chk({tag, "_btaken"}, bus.branch_taken, bus.branch_en_in);
        chk({tag, "_baddr"}, bus.branch_address, exp_ba);
        predict(r, f, v);
        @(posedge clk);
        #1;
        if (!bus.freeze) begin
            m_alu = r; m_store = bus.Val_Rm; m_wb = bus.wb_enable_in;
            m_mr = bus.mem_read_in; m_mw = bus.mem_write_in; m_dest = bus.Dest_in;
        end
        if (bus.S_in && !bus.freeze && !bus.branch_en_in && v) m_status = f;
        chk({tag, "_alu"}, bus.alu_result, m_alu);
        chk({tag, "_store"}, bus.store_val, m_store);
        chk({tag, "_ctl"}, {bus.wb_enable, bus.mem_read, bus.mem_write}, {m_wb, m_mr, m_mw});
        chk({tag, "_dest"}, bus.Dest, m_dest);
        chk({tag, "_status"}, bus.status_out, m_status);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_alu0"}, bus.alu_result, 32'h0);
        chk({tag, "_store0"}, bus.store_val, 32'h0);
        chk({tag, "_ctl0"}, {bus.wb_enable, bus.mem_read, bus.mem_write}, 3'b000);
        chk({tag, "_dest0"}, bus.Dest, 4'h0);
        chk({tag, "_status0"}, bus.status_out, 4'h0);
    endtask

    initial begin
        logic [31:0] hold_alu;
        logic [3:0]  hold_st;
        int          cmds[9] = '{1, 9, 2, 3, 4, 5, 6, 7, 8};

        rst = 1'b1;
        clear_in();
        model_reset();
        #1;
        chk_zero("reset");
        #12 rst = 1'b0;
        @(posedge clk); #1;

        // ADD with signed overflow
        clear_in();
        bus.exec_cmd = 4'b0010; bus.S_in = 1; bus.Val_Rn = 32'h7FFF_FFFF;
        bus.immediate = 1; bus.Shift_operand = 12'h001; bus.Dest_in = 4'd3; bus.wb_enable_in = 1;
        step("add_ovf");
        chk("add_ovf_res", bus.alu_result, 32'h8000_0000);
        chk("add_ovf_st", bus.status_out, 4'b1001);

        // SUB equal operands, then CMP
        clear_in();
        bus.exec_cmd = 4'b0100; bus.S_in = 1; bus.Val_Rn = 5; bus.Val_Rm = 5;
        bus.wb_enable_in = 1; bus.Dest_in = 4'd7;
        step("sub_eq");
        chk("sub_eq_res", bus.alu_result, 32'h0);
        chk("sub_eq_st", bus.status_out, 4'b0110);
        bus.wb_enable_in = 0;
        step("cmp_eq");
        chk("cmp_eq_st", bus.status_out, 4'b0110);

        // MOV of rotated immediate
        clear_in();
        bus.exec_cmd = 4'b0001; bus.immediate = 1; bus.Shift_operand = 12'h4FF;
        step("mov_rot");
        chk("mov_rot_res", bus.alu_result, 32'hFF00_0000);

        // Branch with negative offset; S set but status must not change
        clear_in();
        bus.branch_en_in = 1; bus.PC_in = 32'h100; bus.Signed_imm_24 = 24'hFFFFFE;
        bus.S_in = 1; bus.exec_cmd = 4'b0010; bus.Val_Rn = 32'hFFFF_FFFF;
        bus.immediate = 1; bus.Shift_operand = 12'h002;
        #1;
        chk("br_taken", bus.branch_taken, 1'b1);
        chk("br_addr", bus.branch_address, 32'h0000_00F8);
        step("br");
        chk("br_st", bus.status_out, 4'b0110);

        // Stall: load a known value, then freeze for three cycles
        clear_in();
        bus.exec_cmd = 4'b0111; bus.Val_Rn = 32'h1234_0000; bus.Val_Rm = 32'h0000_5678;
        bus.wb_enable_in = 1; bus.Dest_in = 4'd9;
        step("pre_frz");
        hold_alu = 32'h1234_5678;
        hold_st = bus.status_out;
        chk("pre_frz_res", bus.alu_result, hold_alu);
        clear_in();
        bus.freeze = 1; bus.exec_cmd = 4'b0010; bus.S_in = 1; bus.Val_Rn = 32'hFFFF_FFFF;
        bus.immediate = 1; bus.Shift_operand = 12'h001; bus.Dest_in = 4'd2;
        for (int i = 0; i < 3; i++) begin
            step("frz");
            chk("frz_hold_res", bus.alu_result, hold_alu);
            chk("frz_hold_st", bus.status_out, hold_st);
        end
        bus.freeze = 0;
        step("unfrz");
        chk("unfrz_res", bus.alu_result, 32'h0);
        chk("unfrz_st", bus.status_out, 4'b0110);

        // Reset in the middle of a stall with nonzero outputs
        bus.freeze = 1;
        bus.Val_Rm = 32'hDEAD_BEEF; bus.wb_enable_in = 1;
        bus.freeze = 0;
        step("pre_rst");
        bus.freeze = 1;
        #3 rst = 1'b1;
        #1;
        chk_zero("mid_rst");
        model_reset();
        #1 rst = 1'b0;

        // ADC using carry from Status_in after reset
        clear_in();
        bus.exec_cmd = 4'b0011; bus.Status_in = 4'b0010; bus.Val_Rn = 1;
        bus.immediate = 1; bus.Shift_operand = 12'h001;
        step("adc");
        chk("adc_res", bus.alu_result, 32'd3);

        // Randomized instructions
        for (int it = 0; it < 400; it++) begin
            clear_in();
            bus.exec_cmd = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(10, 15))
                                                         : 4'(cmds[$urandom_range(0, 8)]);
            bus.S_in = 1'($urandom);
            bus.freeze = ($urandom_range(0, 4) == 0);
            bus.branch_en_in = ($urandom_range(0, 9) == 0);
            bus.wb_enable_in = 1'($urandom);
            bus.PC_in = $urandom;
            bus.Val_Rn = ($urandom_range(0, 7) == 0) ? 32'h7FFF_FFFF : $urandom;
            bus.Val_Rm = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            bus.immediate = 1'($urandom);
            bus.Shift_operand = 12'($urandom);
            bus.Signed_imm_24 = 24'($urandom);
            bus.Dest_in = 4'($urandom);
            bus.Status_in = 4'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                bus.exec_cmd = 4'b0010;
                if ($urandom_range(0, 1) == 0) bus.mem_read_in = 1;
                else bus.mem_write_in = 1;
            end
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
